// File: rtl/divider32fp.sv
// divider32fp: sequential IEEE-754 binary32 divider, 26-step restoring division.
// Define DIV_RNE_EN for round-to-nearest-even; otherwise results truncate.
module divider32fp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        div_by_zero_o
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE
  } state_t;

  localparam logic [4:0] F_NAN = 5'b10000;
  localparam logic [4:0] F_INF = 5'b01000;
  localparam logic [4:0] F_OVF = 5'b00100;
  localparam logic [4:0] F_UNF = 5'b00010;
  localparam logic [4:0] F_DBZ = 5'b00001;

  state_t state_q, state_d;

  logic [31:0]       a_q, b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [24:0]       rem_q;
  logic [23:0]       dvs_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  logic              fin_q;
  logic [31:0]       res_q;
  logic [4:0]        flg_q;
  logic [31:0]       quo_o_q;
  logic [4:0]        flg_o_q;
  logic              done_q, busy_q;

  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        sgn, special, ma_lt;
  logic signed [9:0] exp_un;
  logic [31:0] sp_res;
  logic [4:0]  sp_flg;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign ma     = {1'b1, a_q[22:0]};
  assign mb     = {1'b1, b_q[22:0]};
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign sgn    = a_q[31] ^ b_q[31];
  assign special = a_zero | b_zero | (ea == 8'hFF) | (eb == 8'hFF);
  assign ma_lt  = ma < mb;
  assign exp_un = $signed({2'b00, ea}) - $signed({2'b00, eb})
                + 10'sd127 - $signed({9'd0, ma_lt});

  // Subnormals already decode as zero through a_zero/b_zero.
  always_comb begin
    sp_res = {sgn, 31'd0};
    sp_flg = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_res = 32'h7FC00000;
      sp_flg = F_NAN;
    end else if (a_inf) begin
      sp_res = {sgn, 31'h7F800000};
      sp_flg = F_INF;
    end else if (b_zero) begin
      sp_res = {sgn, 31'h7F800000};
      sp_flg = F_INF | F_DBZ;
    end
  end

  logic        ge;
  logic [24:0] rem_nx;

  assign ge     = rem_q >= {1'b0, dvs_q};
  assign rem_nx = ge ? rem_q - {1'b0, dvs_q} : rem_q;

  logic              inc;
  logic [24:0]       man_sum;
  logic [22:0]       man_rn;
  logic signed [9:0] exp_rn;
  logic [31:0]       out_res;
  logic [4:0]        out_flg;

`ifdef DIV_RNE_EN
  assign inc = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
`else
  logic unused_grs;
  assign unused_grs = ^quo_q[1:0];
  assign inc = 1'b0;
`endif

  assign man_sum = {1'b0, quo_q[25:2]} + {24'd0, inc};
  assign man_rn  = man_sum[24] ? man_sum[23:1] : man_sum[22:0];
  assign exp_rn  = man_sum[24] ? exp_q + 10'sd1 : exp_q;

  always_comb begin
    out_res = res_q;
    out_flg = flg_q;
    if (!fin_q) begin
      if (exp_rn >= 10'sd255) begin
        out_res = {sign_q, 31'h7F800000};
        out_flg = F_INF | F_OVF;
      end else begin
        out_res = {sign_q, exp_rn[7:0], man_rn};
        out_flg = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_i) state_d = UNPACK;
      UNPACK:    state_d = special ? ROUND : DIVIDE;
      DIVIDE:    if (cnt_q == 5'd25) state_d = NORMALIZE;
      NORMALIZE: state_d = ROUND;
      ROUND:     state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Specials and underflow park their result in res_q; ROUND is the
  // single point that publishes results, hence the shared 1-cycle slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      quo_o_q <= '0;
      flg_o_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            busy_q <= 1'b1;
            fin_q  <= 1'b0;
          end
        end
        UNPACK: begin
          sign_q <= sgn;
          fin_q  <= special;
          res_q  <= sp_res;
          flg_q  <= sp_flg;
          exp_q  <= exp_un;
          rem_q  <= ma_lt ? {ma, 1'b0} : {1'b0, ma};
          dvs_q  <= mb;
          quo_q  <= '0;
          cnt_q  <= '0;
        end
        DIVIDE: begin
          quo_q <= {quo_q[24:0], ge};
          rem_q <= rem_nx << 1;
          cnt_q <= cnt_q + 5'd1;
        end
        NORMALIZE: begin
          if (exp_q <= 10'sd0) begin
            fin_q <= 1'b1;
            res_q <= {sign_q, 31'd0};
            flg_q <= F_UNF;
          end
        end
        ROUND: begin
          done_q  <= 1'b1;
          quo_o_q <= out_res;
          flg_o_q <= out_flg;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient_o = quo_o_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign {nan_o, infinit_o, overflow_o,
          underflow_o, div_by_zero_o} = flg_o_q;

endmodule
